sec_ded_decoder_pipe: RTL and testbench
=======================================

Name: sec_ded_decoder_pipe

Overview:
- Parametrised, pipelined Hsiao SEC-DED decoder with valid/ready handshakes on both sides.
- Successor to the combinational (104,96) decoder: adds configurable widths, registered stages with backpressure, an error-position output, saturating CE/DUE counters and a first-error syndrome log.
- Sits between the memory read-return path and the consumer; counters and log are read by the RAS/telemetry logic.

Parameters:
- DATA_W, 96, data bits per codeword.
- PAR_W, 8, check bits; CW_W = DATA_W+PAR_W (derived, not overridable).
- CNT_W, 16, width of each saturating error counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword valid.
- in_ready  out  1  decoder can accept.
- codeword_in  in  CW_W  layout {data[DATA_W-1:0], parity[PAR_W-1:0]}.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- data_out  out  DATA_W  corrected data (raw data on DUE).
- status_out  out  2  00 NE, 01 CE, 10 DUE, 11 unused.
- err_pos_out  out  $clog2(CW_W)  flipped codeword bit index; 0 when not CE.
- ce_cnt  out  CNT_W  saturating CE count.
- due_cnt  out  CNT_W  saturating DUE count.
- cnt_clr  in  1  synchronous clear of counters and log.
- log_valid  out  1  first error captured.
- log_syndrome  out  PAR_W  syndrome of first CE/DUE since reset/clear.
- log_status  out  2  status of the logged event.

Behaviour:
H matrix:
- Parity column i (codeword bit i, i < PAR_W) is the one-hot vector 1<<i.
- Data columns are assigned from codeword bit CW_W-1 downward: all weight-3 PAR_W-bit vectors in descending binary value, then weight-5 descending, then weight-7 and so on, until DATA_W columns are used.
- For 96/8 this gives 56 weight-3 columns followed by 40 weight-5 columns; top column is 8'b11100000.

Classification:
- syndrome = XOR of the H columns of all set codeword bits.
- Syndrome 0 → NE.
- Syndrome equal to exactly one H column → CE: flip that bit, err_pos = that index. A parity-bit CE leaves data unchanged.
- Any other syndrome (even weight, or odd weight not in H) → DUE: data passes through uncorrected.

Pipeline (fixed 2 stages):
- S1 registers the codeword and its syndrome.
- S2 registers the corrected data, status and err_pos.
- Latency is 2 cycles from accepted input to out_valid when there is no stall.
- A stage loads when it is empty or its contents are leaving the same cycle.
- in_ready = !s1_valid | s1_advance, where s1_advance = !s2_valid | out_ready.
- Full throughput of 1/cycle with out_ready held high. No bubbles are inserted while stalled.
- out_valid holds and data/status remain stable until out_ready is seen.

Counters and log:
- Updated on the S2 output handshake (out_valid & out_ready), once per beat.
- ce_cnt/due_cnt increment on CE/DUE and saturate at all-ones.
- The log captures syndrome and status on the first CE/DUE handshake while log_valid=0. Later errors do not overwrite it.
- cnt_clr zeroes both counters and log_valid. cnt_clr has priority over a same-cycle event, so that event is not counted or logged.
- cnt_clr does not affect the pipeline.

Reset (async, rst_n=0):
- All valids 0; data/status/err_pos 0; counters 0; log_valid 0; log_syndrome 0; log_status 0.
- in_ready = 1 in the first cycle after reset release.
- Reset during a stall discards in-flight beats.

Decomposition:
- Package sec_ded_pkg holds:
  - enum status_e {ST_NE, ST_CE, ST_DUE}.
  - Function hsiao_col(idx, DATA_W, PAR_W) returning the H column for codeword bit idx.
  - Function hsiao_syndrome(cw) built from hsiao_col.
  - DATA_W/PAR_W defaults.
- One sub-module, sec_ded_err_stats: the counters plus the first-error log, driven by the handshake and status.
- The datapath and pipeline stay in the top.

Test Plan:
- Reset, then codeword {96'h0, 8'h00} with out_ready=1 → out_valid 2 cycles after acceptance, data 0, status 00, counters 0.
- Single flip of bit 103 on an encoded word → syndrome 8'b11100000, data bit 95 restored, status 01, err_pos 103, ce_cnt 1, log_syndrome 8'hE0, log_status 01.
- Flip bits 103 and 102 → syndrome 8'b00110000, status 10, data_out equals the raw corrupted data, due_cnt 1. The log keeps the earlier CE entry.
- Flip parity bit 3 → status 01, err_pos 3, data unchanged.
- Stream 10 back-to-back words, hold out_ready=0 for cycles 3–6 → in_ready drops after 2 beats are buffered, no loss or duplication, order preserved, 1 beat/cycle once released.
- Drive CNT_W=2 with 5 CEs → ce_cnt saturates at 3. cnt_clr coincident with a DUE handshake → due_cnt 0, log_valid 0.

Source files
------------

// File: rtl/sec_ded_pkg.sv
// Shared types and Hsiao H-matrix helpers for the pipelined SEC-DED decoder.
package sec_ded_pkg;

  localparam int DATA_W_DEF = 96;
  localparam int PAR_W_DEF  = 8;
  localparam int MAX_PAR_W  = 16;
  localparam int MAX_CW_W   = 1024;

  typedef enum logic [1:0] {
    ST_NE  = 2'b00,
    ST_CE  = 2'b01,
    ST_DUE = 2'b10
  } status_e;

  // Data columns run from the top codeword bit down: odd weights 3, 5, 7...,
  // each weight class in descending binary value.
  function automatic logic [MAX_PAR_W-1:0] hsiao_col(input int idx, input int data_w,
                                                     input int par_w);
    logic [MAX_PAR_W-1:0] col;
    int k;
    int n;
    col = '0;
    n   = 0;
    if (idx < par_w) begin
      col = MAX_PAR_W'(1) << idx;
    end else begin
      k = data_w + par_w - 1 - idx;
      for (int w = 3; w <= par_w; w += 2) begin
        for (int v = (1 << par_w) - 1; v > 0; v--) begin
          if ($countones(v) == w) begin
            if (n == k) col = MAX_PAR_W'(v);
            n = n + 1;
          end
        end
      end
    end
    return col;
  endfunction

  function automatic logic [MAX_PAR_W-1:0] hsiao_syndrome(input logic [MAX_CW_W-1:0] cw,
                                                          input int data_w, input int par_w);
    logic [MAX_PAR_W-1:0] syn;
    syn = '0;
    for (int i = 0; i < data_w + par_w; i++) begin
      if (cw[i]) syn ^= hsiao_col(i, data_w, par_w);
    end
    return syn;
  endfunction

endpackage

// File: rtl/sec_ded_err_stats.sv
// Saturating CE/DUE counters and first-error syndrome log, updated per output beat.
module sec_ded_err_stats
  import sec_ded_pkg::*;
#(
  parameter int PAR_W = PAR_W_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             evt,
  input  status_e          status,
  input  logic [PAR_W-1:0] syndrome,
  output logic [CNT_W-1:0] ce_cnt,
  output logic [CNT_W-1:0] due_cnt,
  output logic             log_valid,
  output logic [PAR_W-1:0] log_syndrome,
  output logic [1:0]       log_status
);

  logic is_err;
  assign is_err = (status == ST_CE) || (status == ST_DUE);

  // A clear wins over a coincident event, so that event is neither counted nor logged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ce_cnt       <= '0;
      due_cnt      <= '0;
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_status   <= 2'b00;
    end else if (clr) begin
      ce_cnt       <= '0;
      due_cnt      <= '0;
      log_valid    <= 1'b0;
      log_syndrome <= '0;
      log_status   <= 2'b00;
    end else if (evt) begin
      if (status == ST_CE && ce_cnt != '1) ce_cnt <= ce_cnt + 1'b1;
      if (status == ST_DUE && due_cnt != '1) due_cnt <= due_cnt + 1'b1;
      if (!log_valid && is_err) begin
        log_valid    <= 1'b1;
        log_syndrome <= syndrome;
        log_status   <= status;
      end
    end
  end

endmodule

// File: rtl/sec_ded_decoder_pipe.sv
// Two-stage pipelined Hsiao SEC-DED decoder with valid/ready on both sides
// and error statistics taken at the output handshake.
module sec_ded_decoder_pipe
  import sec_ded_pkg::*;
#(
  parameter  int DATA_W = DATA_W_DEF,
  parameter  int PAR_W  = PAR_W_DEF,
  parameter  int CNT_W  = 16,
  localparam int CW_W   = DATA_W + PAR_W,
  localparam int POS_W  = $clog2(CW_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CW_W-1:0]   codeword_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        status_out,
  output logic [POS_W-1:0]  err_pos_out,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  due_cnt,
  input  logic              cnt_clr,
  output logic              log_valid,
  output logic [PAR_W-1:0]  log_syndrome,
  output logic [1:0]        log_status
);

  logic [PAR_W-1:0] col_tab [CW_W];

  for (genvar i = 0; i < CW_W; i++) begin : g_col
    localparam logic [MAX_PAR_W-1:0] COL = hsiao_col(i, DATA_W, PAR_W);
    assign col_tab[i] = COL[PAR_W-1:0];
  end

  logic              s1_valid;
  logic [CW_W-1:0]   s1_cw;
  logic [PAR_W-1:0]  s1_syn;
  logic              s2_valid;
  logic [DATA_W-1:0] s2_data;
  status_e           s2_status;
  logic [POS_W-1:0]  s2_pos;
  logic [PAR_W-1:0]  s2_syn;
  logic              s1_advance;

  assign s1_advance = !s2_valid || out_ready;
  assign in_ready   = !s1_valid || s1_advance;

  logic [PAR_W-1:0] syn_in;

  always_comb begin
    syn_in = '0;
    for (int i = 0; i < CW_W; i++) begin
      if (codeword_in[i]) syn_in ^= col_tab[i];
    end
  end

  logic [CW_W-1:0]   flip;
  logic [POS_W-1:0]  fix_pos;
  logic              hit;
  logic [CW_W-1:0]   fixed_cw;
  status_e           fix_status;
  logic [DATA_W-1:0] fix_data;

  // Columns are all nonzero and distinct, so at most one can match and a zero
  // syndrome never does.
  always_comb begin
    flip    = '0;
    fix_pos = '0;
    hit     = 1'b0;
    for (int i = 0; i < CW_W; i++) begin
      if (s1_syn == col_tab[i]) begin
        flip[i] = 1'b1;
        fix_pos = POS_W'(i);
        hit     = 1'b1;
      end
    end
    fixed_cw = s1_cw ^ flip;
    if (s1_syn == '0) fix_status = ST_NE;
    else if (hit)     fix_status = ST_CE;
    else              fix_status = ST_DUE;
    fix_data = fixed_cw[CW_W-1:PAR_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_cw    <= '0;
      s1_syn   <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_cw  <= codeword_in;
        s1_syn <= syn_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_status <= ST_NE;
      s2_pos    <= '0;
      s2_syn    <= '0;
    end else if (s1_advance) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_data   <= fix_data;
        s2_status <= fix_status;
        s2_pos    <= fix_pos;
        s2_syn    <= s1_syn;
      end
    end
  end

  assign out_valid   = s2_valid;
  assign data_out    = s2_data;
  assign status_out  = s2_status;
  assign err_pos_out = s2_pos;

  sec_ded_err_stats #(
    .PAR_W(PAR_W),
    .CNT_W(CNT_W)
  ) u_stats (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr         (cnt_clr),
    .evt         (s2_valid && out_ready),
    .status      (s2_status),
    .syndrome    (s2_syn),
    .ce_cnt      (ce_cnt),
    .due_cnt     (due_cnt),
    .log_valid   (log_valid),
    .log_syndrome(log_syndrome),
    .log_status  (log_status)
  );

endmodule

// File: tb/tb_sec_ded_decoder_pipe.sv
// Directed bench for sec_ded_decoder_pipe (96/8) with hand-computed H columns,
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
module tb_sec_ded_decoder_pipe;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [103:0] codeword_in;
  logic         out_valid;
  logic         out_ready;
  logic [95:0]  data_out;
  logic [1:0]   status_out;
  logic [6:0]   err_pos_out;
  logic [15:0]  ce_cnt;
  logic [15:0]  due_cnt;
  logic         cnt_clr;
  logic         log_valid;
  logic [7:0]   log_syndrome;
  logic [1:0]   log_status;

  logic         sat_in_ready;
  logic         sat_out_valid;
  logic [95:0]  sat_data;
  logic [1:0]   sat_status;
  logic [6:0]   sat_pos;
  logic [1:0]   sat_ce_cnt;
  logic [1:0]   sat_due_cnt;
  logic         sat_log_valid;
  logic [7:0]   sat_log_syn;
  logic [1:0]   sat_log_status;

  int check_count = 0;
  int err_count   = 0;

  always #5 clk = ~clk;

  sec_ded_decoder_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .codeword_in(codeword_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .status_out(status_out), .err_pos_out(err_pos_out),
    .ce_cnt(ce_cnt), .due_cnt(due_cnt), .cnt_clr(cnt_clr), .log_valid(log_valid),
    .log_syndrome(log_syndrome), .log_status(log_status)
  );

  sec_ded_decoder_pipe #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(sat_in_ready),
    .codeword_in(codeword_in), .out_valid(sat_out_valid), .out_ready(out_ready),
    .data_out(sat_data), .status_out(sat_status), .err_pos_out(sat_pos),
    .ce_cnt(sat_ce_cnt), .due_cnt(sat_due_cnt), .cnt_clr(cnt_clr),
    .log_valid(sat_log_valid), .log_syndrome(sat_log_syn), .log_status(sat_log_status)
  );

  // Clean word: data bits 95, 94, 89 (columns E0, D0, B0) -> parity 8'h80.
  localparam logic [95:0]  D_BASE = 96'hC200_0000_0000_0000_0000_0000;
  localparam logic [103:0] E_WORD = {D_BASE, 8'h80};

  task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
    check_count++;
    if (got !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sends one word, waits for its result and consumes it; optionally pulses
  // cnt_clr in the same cycle as the output handshake.
  task automatic applyStimulus(input logic [103:0] cw, input bit clr_at_out,
                               output logic [95:0] d, output logic [1:0] st,
                               output logic [6:0] pos, output int lat);
    bit ok;
    ok = 1'b0;
    lat = 0;
    d = '0; st = '0; pos = '0;
    @(negedge clk);
    in_valid    = 1'b1;
    codeword_in = cw;
    for (int n = 0; n < 20; n++) begin
      #1;
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) checkOutput("accept_timeout", ok, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ok = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        ok  = 1'b1;
        break;
      end
    end
    if (!ok) checkOutput("out_valid_timeout", ok, 1);
    d   = data_out;
    st  = status_out;
    pos = err_pos_out;
    if (clr_at_out) cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
  endtask

  task automatic runVector(input string tag, input logic [103:0] cw, input logic [95:0] exp_d,
                           input logic [1:0] exp_s, input logic [6:0] exp_p);
    logic [95:0] d;
    logic [1:0]  st;
    logic [6:0]  pos;
    int          lat;
    applyStimulus(cw, 1'b0, d, st, pos, lat);
    checkOutput({tag, "_data"}, d, exp_d);
    checkOutput({tag, "_status"}, st, exp_s);
    checkOutput({tag, "_pos"}, pos, exp_p);
  endtask

  task automatic runStream();
    logic [103:0] words [10];
    logic [95:0]  exp_d [10];
    logic [1:0]   exp_s [10];
    logic [6:0]   exp_p [10];
    int sent, recv, stall, last_c;
    for (int k = 0; k < 8; k++) begin
      words[k] = {96'h0, 8'(1 << k)};
      exp_d[k] = '0;
      exp_s[k] = 2'b01;
      exp_p[k] = 7'(k);
    end
    words[8] = '0;     exp_d[8] = '0;     exp_s[8] = 2'b00; exp_p[8] = '0;
    words[9] = E_WORD; exp_d[9] = D_BASE; exp_s[9] = 2'b00; exp_p[9] = '0;
    sent = 0; recv = 0; stall = 0; last_c = -1;
    for (int c = 0; c < 60 && recv < 10; c++) begin
      @(negedge clk);
      out_ready   = !(c >= 3 && c <= 6);
      in_valid    = (sent < 10);
      codeword_in = (sent < 10) ? words[sent] : '0;
      #1;
      if (out_valid && out_ready) begin
        checkOutput($sformatf("stream_data%0d", recv), data_out, exp_d[recv]);
        checkOutput($sformatf("stream_status%0d", recv), status_out, exp_s[recv]);
        checkOutput($sformatf("stream_pos%0d", recv), err_pos_out, exp_p[recv]);
        recv++;
        last_c = c;
      end
      if (in_valid && !in_ready) stall++;
      if (in_valid && in_ready) sent++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_sent", sent, 10);
    checkOutput("stream_recv", recv, 10);
    checkOutput("stream_stall_cycles", stall, 4);
    checkOutput("stream_last_cycle", last_c, 15);
  endtask

  logic [95:0] d;
  logic [1:0]  st;
  logic [6:0]  pos;
  int          lat;

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    cnt_clr     = 1'b0;
    codeword_in = '0;
    #12;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_data", data_out, 0);
    checkOutput("rst_status", status_out, 0);
    checkOutput("rst_ce_cnt", ce_cnt, 0);
    checkOutput("rst_due_cnt", due_cnt, 0);
    checkOutput("rst_log_valid", log_valid, 0);
    checkOutput("rst_log_syn", log_syndrome, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", in_ready, 1);

    // All-zero codeword: no error, two-cycle latency.
    applyStimulus('0, 1'b0, d, st, pos, lat);
    checkOutput("zero_latency", lat, 2);
    checkOutput("zero_data", d, 0);
    checkOutput("zero_status", st, 2'b00);
    checkOutput("zero_pos", pos, 0);
    checkOutput("zero_ce_cnt", ce_cnt, 0);
    checkOutput("zero_log_valid", log_valid, 0);

    runVector("ce103", E_WORD ^ (104'd1 << 103), D_BASE, 2'b01, 7'd103);
    checkOutput("ce103_ce_cnt", ce_cnt, 1);
    checkOutput("ce103_log_valid", log_valid, 1);
    checkOutput("ce103_log_syn", log_syndrome, 8'hE0);
    checkOutput("ce103_log_status", log_status, 2'b01);

    runVector("due2", E_WORD ^ (104'd3 << 102), 96'h0200_0000_0000_0000_0000_0000, 2'b10, 7'd0);
    checkOutput("due2_due_cnt", due_cnt, 1);
    checkOutput("due2_log_syn", log_syndrome, 8'hE0);
    checkOutput("due2_log_status", log_status, 2'b01);

    runVector("ce_par3", E_WORD ^ 104'h8, D_BASE, 2'b01, 7'd3);
    runVector("ce47", E_WORD ^ (104'd1 << 47), D_BASE, 2'b01, 7'd47);
    // Three parity flips alias onto the last weight-3 column (idx 48).
    runVector("alias48", E_WORD ^ 104'h7, 96'hC200_0000_0000_0100_0000_0000, 2'b01, 7'd48);
    runVector("due_w7", E_WORD ^ 104'hFE, D_BASE, 2'b10, 7'd0);
    runVector("clean", E_WORD, D_BASE, 2'b00, 7'd0);
    checkOutput("dir_ce_cnt", ce_cnt, 4);
    checkOutput("dir_due_cnt", due_cnt, 2);

    runStream();
    checkOutput("stream_ce_cnt", ce_cnt, 12);
    checkOutput("stream_due_cnt", due_cnt, 2);

    // Clear coincident with a DUE handshake.
    applyStimulus(E_WORD ^ (104'd3 << 102), 1'b1, d, st, pos, lat);
    checkOutput("clr_status", st, 2'b10);
    checkOutput("clr_due_cnt", due_cnt, 0);
    checkOutput("clr_ce_cnt", ce_cnt, 0);
    checkOutput("clr_log_valid", log_valid, 0);

    for (int k = 0; k < 5; k++) begin
      applyStimulus({96'h0, 8'(1 << k)}, 1'b0, d, st, pos, lat);
    end
    checkOutput("sat_wide_ce", ce_cnt, 5);
    checkOutput("sat_narrow_ce", sat_ce_cnt, 3);
    checkOutput("sat_narrow_due", sat_due_cnt, 0);
    checkOutput("sat_log_valid", sat_log_valid, 1);
    checkOutput("sat_log_syn", log_syndrome, 8'h01);
    checkOutput("sat_log_status", log_status, 2'b01);

    // Reset while two beats are stalled in the pipe.
    @(negedge clk);
    out_ready   = 1'b0;
    in_valid    = 1'b1;
    codeword_in = {96'h0, 8'h01};
    @(negedge clk);
    codeword_in = {96'h0, 8'h02};
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checkOutput("stall_in_ready", in_ready, 0);
    checkOutput("stall_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #2;
    checkOutput("stall_rst_out_valid", out_valid, 0);
    checkOutput("stall_rst_ce_cnt", ce_cnt, 0);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    checkOutput("stall_rel_in_ready", in_ready, 1);
    repeat (4) @(negedge clk);
    checkOutput("stall_no_ghost", out_valid, 0);
    checkOutput("stall_no_count", ce_cnt, 0);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
